// File: rtl/cpu_axi_burst_bridge.sv
// Bridge from two SRAM-like masters (instruction read port, data read/write
// port) onto one AXI3 master. The read and write channels run independent
// FSMs, so an instruction burst can overlap a data write.
module cpu_axi_burst_bridge #(
  parameter int ID_W    = 4,
  parameter int INST_ID = 0,
  parameter int DATA_ID = 1,
  parameter int LEN_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  // instruction port
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  input  logic [LEN_W-1:0]  inst_len,
  output logic [31:0]       inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic              inst_last,
  output logic              inst_err,
  // data port
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [LEN_W-1:0]  data_len,
  output logic [31:0]       data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              data_last,
  output logic              data_err,
  // AXI read address
  output logic [ID_W-1:0]   arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data
  input  logic [ID_W-1:0]   rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AXI write address
  output logic [ID_W-1:0]   awid,
  output logic [31:0]       awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  // AXI write data
  output logic [ID_W-1:0]   wid,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI write response
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [ID_W-1:0] INST_ARID = ID_W'(INST_ID);
  localparam logic [ID_W-1:0] DATA_XID  = ID_W'(DATA_ID);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic              r_owner_data;
  logic [31:0]       ar_addr_q;
  logic [LEN_W-1:0]  ar_len_q;
  logic [2:0]        ar_size_q;
  logic [31:0]       aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic [2:0]        aw_size_q;
  logic              aw_done;
  logic              w_done;

  logic r_idle, w_idle;
  logic data_rd_ok, data_wr_ok;
  logic data_rd_acc, data_wr_acc, inst_acc;
  logic r_beat, b_fire, data_beat;
  logic [3:0] strb_calc;
  logic unused_ok;

  assign r_idle = (r_state == R_IDLE);
  assign w_idle = (w_state == W_IDLE);

  // Data reads wait for the write path to drain; data writes wait for a
  // data-owned read, so the data port never has two transactions in flight.
  assign data_rd_ok   = r_idle && w_idle;
  assign data_wr_ok   = w_idle && !(!r_idle && r_owner_data);
  assign data_addr_ok = data_wr ? data_wr_ok : data_rd_ok;
  assign inst_addr_ok = r_idle && !(data_req && !data_wr && w_idle);

  assign data_rd_acc = data_req && !data_wr && data_addr_ok;
  assign data_wr_acc = data_req && data_wr && data_addr_ok;
  assign inst_acc    = inst_req && inst_addr_ok;

  // byte lanes for narrow writes
  always_comb begin
    strb_calc = 4'b1111;
    case (data_size)
      2'd0:    strb_calc = 4'b0001 << data_addr[1:0];
      2'd1:    strb_calc = 4'b0011 << data_addr[1:0];
      default: strb_calc = 4'b1111;
    endcase
  end

  // read FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // read FSM next state and AR/R handshake outputs
  always_comb begin
    r_next  = r_state;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (r_state)
      R_IDLE: if (data_rd_acc || inst_acc) r_next = R_ADDR;
      R_ADDR: begin
        arvalid = 1'b1;
        if (arready) r_next = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // capture the winning read request; bursts always use full-word beats
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_data <= 1'b0;
      ar_addr_q    <= '0;
      ar_len_q     <= '0;
      ar_size_q    <= '0;
    end else if (r_idle) begin
      if (data_rd_acc) begin
        r_owner_data <= 1'b1;
        ar_addr_q    <= data_addr;
        ar_len_q     <= data_len;
        ar_size_q    <= (data_len != '0) ? 3'd2 : {1'b0, data_size};
      end else if (inst_acc) begin
        r_owner_data <= 1'b0;
        ar_addr_q    <= inst_addr;
        ar_len_q     <= inst_len;
        ar_size_q    <= 3'd2;
      end
    end
  end

  // write FSM state register
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // write FSM next state and AW/W/B handshake outputs
  always_comb begin
    w_next  = w_state;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (w_state)
      W_IDLE: if (data_wr_acc) w_next = W_SEND;
      W_SEND: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        // AW and W complete independently, in either order or together
        if ((aw_done || awready) && (w_done || wready)) w_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // capture write request fields and track AW/W completion
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_size_q <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      if (w_idle && data_wr_acc) begin
        aw_addr_q <= data_addr;
        w_data_q  <= data_wdata;
        w_strb_q  <= strb_calc;
        aw_size_q <= {1'b0, data_size};
      end
      if (w_state == W_SEND) begin
        if (w_next == W_RESP) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (awvalid && awready) aw_done <= 1'b1;
          if (wvalid && wready)   w_done  <= 1'b1;
        end
      end
    end
  end

  assign r_beat    = rvalid && rready;
  assign b_fire    = bvalid && bready;
  assign data_beat = r_beat && r_owner_data;

  assign inst_rdata   = rdata;
  assign inst_data_ok = r_beat && !r_owner_data;
  assign inst_last    = inst_data_ok && rlast;
  assign inst_err     = inst_data_ok && (rresp != 2'b00);

  assign data_rdata   = rdata;
  assign data_data_ok = data_beat || b_fire;
  assign data_last    = (data_beat && rlast) || b_fire;
  assign data_err     = (data_beat && (rresp != 2'b00)) || (b_fire && (bresp != 2'b00));

  assign arid    = r_owner_data ? DATA_XID : INST_ARID;
  assign araddr  = ar_addr_q;
  assign arlen   = 8'(ar_len_q);
  assign arsize  = ar_size_q;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign awid    = DATA_XID;
  assign awaddr  = aw_addr_q;
  assign awlen   = '0;
  assign awsize  = aw_size_q;
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

  assign wid   = awid;
  assign wdata = w_data_q;
  assign wstrb = w_strb_q;
  assign wlast = 1'b1;

  // response IDs are not needed: each channel has a single known owner
  assign unused_ok = ^{rid, bid};

endmodule

// File: tb/tb_cpu_axi_burst_bridge.sv
// Directed bench for cpu_axi_burst_bridge: table-driven write/read vectors
// plus hand-written multi-cycle sequences.
module tb_cpu_axi_burst_bridge;

  localparam int ID_W  = 4;
  localparam int LEN_W = 3;

  logic clk = 1'b0;
  logic rst;
  logic inst_req;
  logic [31:0] inst_addr;
  logic [LEN_W-1:0] inst_len;
  logic [31:0] inst_rdata;
  logic inst_addr_ok, inst_data_ok, inst_last, inst_err;
  logic data_req, data_wr;
  logic [1:0] data_size;
  logic [31:0] data_addr, data_wdata;
  logic [LEN_W-1:0] data_len;
  logic [31:0] data_rdata;
  logic data_addr_ok, data_data_ok, data_last, data_err;
  logic [ID_W-1:0] arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
  logic [3:0] arcache, awcache, wstrb;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  cpu_axi_burst_bridge #(.ID_W(ID_W), .INST_ID(0), .DATA_ID(1), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_len(inst_len),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_last(inst_last), .inst_err(inst_err),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_len(data_len), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_last(data_last),
    .data_err(data_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  br;
    logic [3:0]  exp_strb;
    logic [2:0]  exp_awsize;
    logic        exp_err;
  } wvec_t;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [1:0]       size;
    logic [31:0]      addr;
    logic [2:0]       exp_arsize;
    logic [7:0]       exp_arlen;
  } rvec_t;

  wvec_t wv[9];
  rvec_t rv[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_write(input wvec_t v, input string tag);
    step();
    data_req = 1'b1; data_wr = 1'b1; data_size = v.size; data_addr = v.addr; data_wdata = v.wd;
    settle();
    check({tag, ".addr_ok"}, 32'(data_addr_ok), 1);
    step();
    data_req = 1'b0; awready = 1'b1; wready = 1'b1;
    settle();
    check({tag, ".awvalid"}, 32'(awvalid), 1);
    check({tag, ".wvalid"}, 32'(wvalid), 1);
    check({tag, ".wstrb"}, 32'(wstrb), 32'(v.exp_strb));
    check({tag, ".awsize"}, 32'(awsize), 32'(v.exp_awsize));
    check({tag, ".awaddr"}, awaddr, v.addr);
    check({tag, ".wdata"}, wdata, v.wd);
    step();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = v.br;
    settle();
    check({tag, ".b_ok"}, 32'(data_data_ok), 1);
    check({tag, ".b_err"}, 32'(data_err), 32'(v.exp_err));
    step();
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic do_data_read(input rvec_t v, input string tag);
    step();
    data_req = 1'b1; data_wr = 1'b0; data_len = v.len; data_size = v.size; data_addr = v.addr;
    settle();
    check({tag, ".addr_ok"}, 32'(data_addr_ok), 1);
    step();
    data_req = 1'b0; arready = 1'b1;
    settle();
    check({tag, ".arvalid"}, 32'(arvalid), 1);
    check({tag, ".arid"}, 32'(arid), 1);
    check({tag, ".arlen"}, 32'(arlen), 32'(v.exp_arlen));
    check({tag, ".arsize"}, 32'(arsize), 32'(v.exp_arsize));
    step();
    arready = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      rvalid = 1'b1; rdata = 32'hB000 + 32'(i); rlast = (i == int'(v.len)); rresp = 2'b00;
      settle();
      check({tag, ".beat_ok"}, 32'(data_data_ok), 1);
      check({tag, ".rdata"}, data_rdata, 32'hB000 + 32'(i));
      check({tag, ".last"}, 32'(data_last), (i == int'(v.len)) ? 1 : 0);
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    settle();
    check({tag, ".idle"}, 32'(data_addr_ok), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wv[0] = '{2'd0, 32'h0000_3000, 32'h11, 2'b00, 4'b0001, 3'd0, 1'b0};
    wv[1] = '{2'd0, 32'h0000_3001, 32'h22, 2'b00, 4'b0010, 3'd0, 1'b0};
    wv[2] = '{2'd0, 32'h0000_3002, 32'h33, 2'b00, 4'b0100, 3'd0, 1'b0};
    wv[3] = '{2'd0, 32'h0000_3003, 32'h44, 2'b10, 4'b1000, 3'd0, 1'b1};
    wv[4] = '{2'd1, 32'h0000_3000, 32'h5555, 2'b00, 4'b0011, 3'd1, 1'b0};
    wv[5] = '{2'd1, 32'h0000_3002, 32'h6666, 2'b11, 4'b1100, 3'd1, 1'b1};
    wv[6] = '{2'd1, 32'h0000_3003, 32'h7777, 2'b00, 4'b1000, 3'd1, 1'b0};
    wv[7] = '{2'd2, 32'h0000_3004, 32'hCAFE_F00D, 2'b00, 4'b1111, 3'd2, 1'b0};
    wv[8] = '{2'd3, 32'h0000_3008, 32'h0BAD_BEEF, 2'b01, 4'b1111, 3'd3, 1'b1};

    rv[0] = '{3'd0, 2'd0, 32'h0000_8001, 3'd0, 8'd0};
    rv[1] = '{3'd0, 2'd1, 32'h0000_8002, 3'd1, 8'd0};
    rv[2] = '{3'd0, 2'd2, 32'h0000_8004, 3'd2, 8'd0};
    rv[3] = '{3'd3, 2'd0, 32'h0000_8010, 3'd2, 8'd3};
    rv[4] = '{3'd7, 2'd1, 32'h0000_8020, 3'd2, 8'd7};
    rv[5] = '{3'd1, 2'd2, 32'h0000_8040, 3'd2, 8'd1};

    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0; inst_len = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0; data_len = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'b00; bvalid = 1'b0;

    // reset state
    repeat (3) step();
    settle();
    check("rst.arvalid", 32'(arvalid), 0);
    check("rst.awvalid", 32'(awvalid), 0);
    check("rst.wvalid", 32'(wvalid), 0);
    check("rst.rready", 32'(rready), 0);
    check("rst.bready", 32'(bready), 0);
    check("rst.data_ok", 32'({inst_data_ok, data_data_ok, inst_last, data_last, inst_err, data_err}), 0);
    step();
    rst = 1'b0;

    // instruction burst of 8 beats
    inst_req = 1'b1; inst_addr = 32'h1000; inst_len = 3'd7;
    settle();
    check("ib.addr_ok", 32'(inst_addr_ok), 1);
    step();
    inst_req = 1'b0; arready = 1'b1;
    settle();
    check("ib.arvalid", 32'(arvalid), 1);
    check("ib.araddr", araddr, 32'h1000);
    check("ib.arlen", 32'(arlen), 7);
    check("ib.arburst", 32'(arburst), 1);
    check("ib.arsize", 32'(arsize), 2);
    check("ib.arid", 32'(arid), 0);
    check("ib.const", 32'({arlock, arcache, arprot}), 0);
    check("ib.rready_addr", 32'(rready), 0);
    step();
    arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rvalid = 1'b1; rdata = 32'hA0 + 32'(i); rlast = (i == 7);
      settle();
      check("ib.beat_ok", 32'(inst_data_ok), 1);
      check("ib.rdata", inst_rdata, 32'hA0 + 32'(i));
      check("ib.last", 32'(inst_last), (i == 7) ? 1 : 0);
      check("ib.data_ok_quiet", 32'(data_data_ok), 0);
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    settle();
    check("ib.idle", 32'(inst_addr_ok), 1);
    check("ib.rready_idle", 32'(rready), 0);

    // data write overlapping an instruction burst
    step();
    inst_req = 1'b1; inst_addr = 32'h1100; inst_len = 3'd3;
    step();
    inst_req = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hC0; rlast = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h2000; data_wdata = 32'h1234_5678;
    settle();
    check("cc.wr_addr_ok", 32'(data_addr_ok), 1);
    check("cc.beat0", 32'(inst_data_ok), 1);
    step();
    data_req = 1'b0; awready = 1'b1; wready = 1'b1; rdata = 32'hC1;
    settle();
    check("cc.awvalid", 32'(awvalid), 1);
    check("cc.wvalid", 32'(wvalid), 1);
    check("cc.rready", 32'(rready), 1);
    check("cc.awaddr", awaddr, 32'h2000);
    check("cc.wdata", wdata, 32'h1234_5678);
    check("cc.wstrb", 32'(wstrb), 32'hF);
    check("cc.awlen", 32'(awlen), 0);
    check("cc.wlast", 32'(wlast), 1);
    check("cc.ids", 32'({awid, wid}), 32'h11);
    check("cc.awburst", 32'(awburst), 1);
    check("cc.beat1", 32'(inst_data_ok), 1);
    step();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; rdata = 32'hC2;
    settle();
    check("cc.bready", 32'(bready), 1);
    check("cc.b_ok", 32'(data_data_ok), 1);
    check("cc.b_last", 32'(data_last), 1);
    check("cc.b_err", 32'(data_err), 0);
    check("cc.beat2", 32'(inst_data_ok), 1);
    step();
    bvalid = 1'b0; rdata = 32'hC3; rlast = 1'b1;
    settle();
    check("cc.beat3_last", 32'(inst_last), 1);
    check("cc.no_data_ok", 32'(data_data_ok), 0);
    step();
    rvalid = 1'b0; rlast = 1'b0;

    // byte write with AW arriving three cycles after W
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h3003; data_wdata = 32'hEE00_0000;
    settle();
    check("bw.addr_ok", 32'(data_addr_ok), 1);
    step();
    data_req = 1'b0; wready = 1'b1;
    settle();
    check("bw.wstrb", 32'(wstrb), 32'h8);
    check("bw.wvalid", 32'(wvalid), 1);
    step();
    wready = 1'b0;
    settle();
    check("bw.wvalid_done", 32'(wvalid), 0);
    check("bw.aw_wait1", 32'(awvalid), 1);
    step();
    settle();
    check("bw.aw_wait2", 32'(awvalid), 1);
    step();
    awready = 1'b1;
    settle();
    check("bw.aw_wait3", 32'(awvalid), 1);
    step();
    awready = 1'b0;
    settle();
    check("bw.aw_cleared", 32'(awvalid), 0);
    check("bw.bready", 32'(bready), 1);
    check("bw.no_early_ok", 32'(data_data_ok), 0);
    step();
    bvalid = 1'b1;
    settle();
    check("bw.b_ok", 32'(data_data_ok), 1);
    step();
    bvalid = 1'b0;
    settle();
    check("bw.single", 32'({awvalid, wvalid, bready, data_data_ok}), 0);

    // read-after-write hazard
    step();
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h4100; data_wdata = 32'h99;
    step();
    data_wr = 1'b0; data_addr = 32'h4000; data_len = 3'd0; data_size = 2'd2;
    inst_req = 1'b1; inst_addr = 32'h5000; inst_len = 3'd0;
    settle();
    check("rw.rd_blocked", 32'(data_addr_ok), 0);
    check("rw.inst_ok", 32'(inst_addr_ok), 1);
    step();
    inst_req = 1'b0; arready = 1'b1; awready = 1'b1; wready = 1'b1;
    settle();
    check("rw.arid_inst", 32'(arid), 0);
    check("rw.araddr", araddr, 32'h5000);
    check("rw.rd_blocked2", 32'(data_addr_ok), 0);
    step();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5A5A;
    settle();
    check("rw.inst_beat", 32'(inst_data_ok), 1);
    check("rw.rd_blocked3", 32'(data_addr_ok), 0);
    step();
    rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b1;
    settle();
    check("rw.b_ok", 32'(data_data_ok), 1);
    check("rw.rd_blocked4", 32'(data_addr_ok), 0);
    step();
    bvalid = 1'b0;
    settle();
    check("rw.rd_released", 32'(data_addr_ok), 1);
    step();
    data_req = 1'b0; arready = 1'b1;
    settle();
    check("rw.arid_data", 32'(arid), 1);
    check("rw.araddr_data", araddr, 32'h4000);
    step();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'hDEAD;
    settle();
    check("rw.data_beat", 32'(data_data_ok), 1);
    check("rw.data_rdata", data_rdata, 32'hDEAD);
    check("rw.inst_quiet", 32'(inst_data_ok), 0);
    step();
    rvalid = 1'b0; rlast = 1'b0;

    // simultaneous data and instruction reads, error response
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h6002; data_len = 3'd0;
    inst_req = 1'b1; inst_addr = 32'h6100; inst_len = 3'd0;
    settle();
    check("sim.data_ok", 32'(data_addr_ok), 1);
    check("sim.inst_blocked", 32'(inst_addr_ok), 0);
    step();
    data_req = 1'b0; inst_req = 1'b0; arready = 1'b1;
    settle();
    check("sim.arid", 32'(arid), 1);
    check("sim.arsize", 32'(arsize), 1);
    check("sim.araddr", araddr, 32'h6002);
    step();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rresp = 2'b10;
    settle();
    check("sim.err", 32'(data_err), 1);
    check("sim.beat", 32'(data_data_ok), 1);
    check("sim.inst_err_quiet", 32'(inst_err), 0);
    step();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;

    // reset during an instruction burst with a write pending
    inst_req = 1'b1; inst_addr = 32'h7000; inst_len = 3'd7;
    step();
    inst_req = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rdata = 32'h70 + 32'(i); rlast = 1'b0;
      if (i == 0) begin
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h7800; data_wdata = 32'h1;
      end else begin
        data_req = 1'b0;
      end
      settle();
      check("mr.beat", 32'(inst_data_ok), 1);
      step();
    end
    rst = 1'b1; rvalid = 1'b1;
    step();
    settle();
    check("mr.valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 0);
    check("mr.oks", 32'({inst_data_ok, data_data_ok, inst_last, data_last}), 0);
    step();
    rst = 1'b0; rvalid = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h7100; inst_len = 3'd0;
    settle();
    check("mr.inst_ok", 32'(inst_addr_ok), 1);
    check("mr.wr_idle", 32'({awvalid, wvalid}), 0);
    step();
    inst_req = 1'b0; arready = 1'b1;
    settle();
    check("mr.arvalid", 32'(arvalid), 1);
    check("mr.araddr", araddr, 32'h7100);
    check("mr.arlen", 32'(arlen), 0);
    step();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h71;
    settle();
    check("mr.last", 32'(inst_last), 1);
    step();
    rvalid = 1'b0; rlast = 1'b0;

    // table: write strobes, sizes and B errors
    for (int i = 0; i < 9; i++) do_write(wv[i], $sformatf("wv%0d", i));

    // table: data read sizes and burst lengths
    for (int i = 0; i < 6; i++) do_data_read(rv[i], $sformatf("rv%0d", i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
